// File: rtl/vslc_pkg.sv
// rtl/vslc_pkg.sv - shared types and constants for the VSLC scan sequencer
package vslc_pkg;

    localparam int OPCODE_W = 8;
    localparam logic [OPCODE_W-1:0] END_OP_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        FETCH,
        ISSUE,
        COMMIT,
        WAIT
    } scan_state_e;

endpackage

// File: rtl/vslc_scan_timer.sv
// rtl/vslc_scan_timer.sv - saturating cycles-since-LATCH counter and scan-period compare
module vslc_scan_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic                count_en,
    input  logic [PERIOD_W-1:0] scan_period,
    output logic                done
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W:0]   cnt_inc;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (count_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // One extra bit so the +1 never wraps when the counter has saturated.
    assign cnt_inc = {1'b0, cnt_q} + (PERIOD_W + 1)'(1);
    assign done    = (cnt_inc >= {1'b0, scan_period});

endmodule

// File: rtl/vslc_scan_sequencer.sv
// rtl/vslc_scan_sequencer.sv - scan-cycle controller: latch, clear, fetch/issue to END, commit, wait
module vslc_scan_sequencer
    import vslc_pkg::*;
#(
    parameter int                  ADDR_W    = 8,
    parameter int                  IO_W      = 8,
    parameter int                  PERIOD_W  = 16,
    parameter int                  MAX_INSTR = 255,
    parameter logic [OPCODE_W-1:0] END_OP    = END_OP_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [PERIOD_W-1:0] scan_period,
    input  logic [IO_W-1:0]     in_pins,
    output logic [IO_W-1:0]     in_image,
    output logic                fetch_req,
    output logic [ADDR_W-1:0]   fetch_addr,
    input  logic                fetch_ack,
    input  logic [OPCODE_W-1:0] fetch_data,
    output logic                ex_valid,
    output logic [OPCODE_W-1:0] ex_instr,
    input  logic                ex_ready,
    output logic                ex_clear,
    input  logic [IO_W-1:0]     ex_out_image,
    output logic [IO_W-1:0]     out_pins,
    output logic                busy,
    output logic                fault,
    output logic [15:0]         scan_count
);

    localparam int ICNT_W = $clog2(MAX_INSTR + 1);

    scan_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [IO_W-1:0]     in_image_q, in_image_d;
    logic [IO_W-1:0]     out_pins_q, out_pins_d;
    logic [OPCODE_W-1:0] ex_instr_q, ex_instr_d;
    logic [ICNT_W-1:0]   icnt_q, icnt_d;
    logic [15:0]         scan_count_q, scan_count_d;
    logic                fault_q, fault_d;
    logic                fetch_req_q, fetch_req_d;
    logic                ex_valid_q, ex_valid_d;
    logic                ex_clear_q, ex_clear_d;
    logic                busy_q, busy_d;
    logic                timer_done;

    vslc_scan_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .restart     (state_d == LATCH),
        .count_en    (state_q != IDLE),
        .scan_period (scan_period),
        .done        (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        in_image_d   = in_image_q;
        out_pins_d   = out_pins_q;
        ex_instr_d   = ex_instr_q;
        icnt_d       = icnt_q;
        scan_count_d = scan_count_q;
        fault_d      = fault_q;

        case (state_q)
            IDLE: begin
                if (run && !fault_q) state_d = LATCH;
            end
            LATCH: begin
                in_image_d   = in_pins;
                fetch_addr_d = '0;
                icnt_d       = '0;
                state_d      = FETCH;
            end
            FETCH: begin
                if (fetch_ack) begin
                    if (fetch_data == END_OP) begin
                        state_d = COMMIT;
                    end else begin
                        ex_instr_d = fetch_data;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ex_ready) begin
                    fetch_addr_d = fetch_addr_q + ADDR_W'(1);
                    icnt_d       = icnt_q + ICNT_W'(1);
                    if (icnt_d == ICNT_W'(MAX_INSTR)) begin
                        fault_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            COMMIT: begin
                out_pins_d   = ex_out_image;
                scan_count_d = scan_count_q + 16'd1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (timer_done) state_d = (run && !fault_q) ? LATCH : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered decodes of the next state so they line up with state_q.
        fetch_req_d = (state_d == FETCH);
        ex_valid_d  = (state_d == ISSUE);
        ex_clear_d  = (state_d == LATCH);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            in_image_q   <= '0;
            out_pins_q   <= '0;
            ex_instr_q   <= '0;
            icnt_q       <= '0;
            scan_count_q <= '0;
            fault_q      <= 1'b0;
            fetch_req_q  <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_clear_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            in_image_q   <= in_image_d;
            out_pins_q   <= out_pins_d;
            ex_instr_q   <= ex_instr_d;
            icnt_q       <= icnt_d;
            scan_count_q <= scan_count_d;
            fault_q      <= fault_d;
            fetch_req_q  <= fetch_req_d;
            ex_valid_q   <= ex_valid_d;
            ex_clear_q   <= ex_clear_d;
            busy_q       <= busy_d;
        end
    end

    assign in_image   = in_image_q;
    assign fetch_req  = fetch_req_q;
    assign fetch_addr = fetch_addr_q;
    assign ex_valid   = ex_valid_q;
    assign ex_instr   = ex_instr_q;
    assign ex_clear   = ex_clear_q;
    assign out_pins   = out_pins_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign scan_count = scan_count_q;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// tb/tb_vslc_scan_sequencer.sv - randomized bench for vslc_scan_sequencer against a scan-level model
module tb_vslc_scan_sequencer;

    localparam int ADDR_W    = 4;
    localparam int IO_W      = 8;
    localparam int PERIOD_W  = 16;
    localparam int MAX_INSTR = 20;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam logic [7:0] END_OP = 8'hFF;

    logic                clk          = 1'b0;
    logic                rst          = 1'b1;
    logic                run          = 1'b0;
    logic [PERIOD_W-1:0] scan_period  = '0;
    logic [IO_W-1:0]     in_pins      = '0;
    logic                fetch_ack    = 1'b0;
    logic [7:0]          fetch_data   = '0;
    logic                ex_ready     = 1'b0;
    logic [IO_W-1:0]     ex_out_image = '0;

    logic [IO_W-1:0]     in_image;
    logic                fetch_req;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                ex_valid;
    logic [7:0]          ex_instr;
    logic                ex_clear;
    logic [IO_W-1:0]     out_pins;
    logic                busy;
    logic                fault;
    logic [15:0]         scan_count;

    always #5 clk = ~clk;

    vslc_scan_sequencer #(
        .ADDR_W    (ADDR_W),
        .IO_W      (IO_W),
        .PERIOD_W  (PERIOD_W),
        .MAX_INSTR (MAX_INSTR),
        .END_OP    (END_OP)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .scan_period  (scan_period),
        .in_pins      (in_pins),
        .in_image     (in_image),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .fetch_data   (fetch_data),
        .ex_valid     (ex_valid),
        .ex_instr     (ex_instr),
        .ex_ready     (ex_ready),
        .ex_clear     (ex_clear),
        .ex_out_image (ex_out_image),
        .out_pins     (out_pins),
        .busy         (busy),
        .fault        (fault),
        .scan_count   (scan_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Stimulus knobs, written by the main sequence only.
    int   ack_max   = 0;
    int   ack_fix   = -1;
    int   ready_pct = 100;
    int   hold_len  = 0;
    bit   noise     = 1'b0;
    bit   wrap_mode = 1'b0;
    logic [7:0] mem [DEPTH];

    // Scan-level reference model.
    int         m_addr    = 0;
    int         m_icnt    = 0;
    int         latch_cyc = 0;
    int         exp_latch = -1;
    bit         m_idle    = 1'b1;
    bit         m_fault   = 1'b0;
    logic [15:0] m_scans  = '0;
    logic [7:0] m_out     = '0;
    logic [7:0] exp_out   = '0;
    logic [7:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_program(input int len);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < len)       mem[i] = 8'($urandom_range(0, 254));
            else if (i == len) mem[i] = END_OP;
            else               mem[i] = 8'($urandom);
        end
    endtask

    task automatic wait_clears(input int n, input int budget, input string tag);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            tick();
            t++;
            if (ex_clear) seen++;
        end
        check_eq(tag, seen, n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int t = 0;
        while (busy && t < budget) begin
            tick();
            t++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    initial begin : monitor
        int ack_wait = 0;
        int hold_cnt = 0;
        int c;
        bit wrap_seen = 1'b0;
        logic cand_f = 1'b0, cand_e = 1'b0;
        logic [ADDR_W-1:0] cand_addr = '0;
        logic [7:0] cand_data = '0, cand_instr = '0;
        logic p_ev = 1'b0, p_er = 1'b0, p_fr = 1'b0, p_fa = 1'b0;
        logic [7:0] p_instr = '0;
        logic [ADDR_W-1:0] p_addr = '0;
        logic commit_cap = 1'b0, commit_chk = 1'b0, in_chk = 1'b0;
        logic [7:0] exp_in = '0;
        logic exp_clear;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                check_eq("rst_zero_data", {in_image, ex_instr, out_pins, fetch_addr}, 0);
                check_eq("rst_zero_ctrl", {scan_count, fetch_req, ex_valid, ex_clear, busy, fault}, 0);
                m_idle = 1'b1; m_fault = 1'b0; m_scans = '0; m_out = '0;
                exp_latch = -1; exp_q.delete();
                cand_f = 1'b0; cand_e = 1'b0; p_ev = 1'b0; p_fr = 1'b0;
                commit_cap = 1'b0; commit_chk = 1'b0; in_chk = 1'b0;
                fetch_ack = 1'b0; ex_ready = 1'b0; hold_cnt = hold_len; ack_wait = 0;
                continue;
            end

            // Handshakes that completed on the edge just taken.
            if (cand_f) begin
                check_eq("fetch_addr", cand_addr, m_addr);
                if (cand_data == END_OP) begin
                    c = cyc - latch_cyc;
                    exp_latch = latch_cyc + ((int'(scan_period) > c + 2) ? int'(scan_period) : c + 2);
                    commit_cap = 1'b1;
                    m_scans++;
                end else begin
                    exp_q.push_back(cand_data);
                end
            end
            if (cand_e) begin
                if (exp_q.size() == 0) check_eq("issue_unexpected", 1, 0);
                else check_eq("ex_instr", cand_instr, exp_q.pop_front());
                m_addr = (m_addr + 1) % DEPTH;
                m_icnt++;
                if (m_icnt == MAX_INSTR) begin
                    check_eq("wd_fault", fault, 1'b1);
                    check_eq("wd_out_hold", out_pins, m_out);
                    m_fault = 1'b1; m_idle = 1'b1; exp_latch = -1;
                end
            end

            if (commit_chk) begin
                check_eq("out_pins", out_pins, exp_out);
                check_eq("scan_count", scan_count, m_scans);
                m_out = exp_out;
                commit_chk = 1'b0;
            end
            if (in_chk) begin
                check_eq("in_image", in_image, exp_in);
                in_chk = 1'b0;
            end
            check_eq("req_valid_excl", fetch_req & ex_valid, 1'b0);
            if (p_ev && !p_er) check_eq("ex_hold", {ex_valid, ex_instr}, {1'b1, p_instr});
            if (p_fr && !p_fa) check_eq("fetch_hold", {fetch_req, fetch_addr}, {1'b1, p_addr});

            exp_clear = m_idle ? (run && !m_fault) : ((cyc == exp_latch) && run);
            check_eq("ex_clear", ex_clear, exp_clear);
            if (exp_clear) begin
                m_idle = 1'b0; latch_cyc = cyc; m_addr = 0; m_icnt = 0;
                exp_latch = -1; exp_q.delete();
            end else if (!m_idle && cyc == exp_latch) begin
                m_idle = 1'b1; exp_latch = -1;
            end
            check_eq("busy", busy, !m_idle);
            check_eq("fault", fault, m_fault);

            // Drive the memory, executor and pins for this cycle.
            ex_out_image = 8'($urandom);
            in_pins      = 8'($urandom);
            if (!wrap_mode) wrap_seen = 1'b0;
            if (fetch_req) begin
                if (ack_wait > 0) begin
                    fetch_ack = 1'b0;
                    ack_wait--;
                end else begin
                    fetch_ack = 1'b1;
                    if (wrap_mode && fetch_addr == '0) begin
                        fetch_data = wrap_seen ? END_OP : mem[0];
                        wrap_seen  = 1'b1;
                    end else begin
                        fetch_data = mem[fetch_addr];
                    end
                end
            end else begin
                ack_wait   = (ack_fix >= 0) ? ack_fix : $urandom_range(0, ack_max);
                fetch_ack  = noise && ($urandom_range(0, 3) == 0);
                fetch_data = 8'($urandom);
            end
            if (ex_valid) begin
                if (hold_cnt > 0) begin
                    ex_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    ex_ready = ($urandom_range(1, 100) <= ready_pct);
                end
            end else begin
                ex_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                hold_cnt = hold_len;
            end

            if (commit_cap) begin
                exp_out = ex_out_image; commit_cap = 1'b0; commit_chk = 1'b1;
            end
            if (exp_clear) begin
                exp_in = in_pins; in_chk = 1'b1;
            end

            cand_f = fetch_req && fetch_ack; cand_addr = fetch_addr; cand_data = fetch_data;
            cand_e = ex_valid && ex_ready;   cand_instr = ex_instr;
            p_ev = ex_valid; p_er = ex_ready; p_instr = ex_instr;
            p_fr = fetch_req; p_fa = fetch_ack; p_addr = fetch_addr;
        end
    end

    initial begin : main
        logic [15:0] saved;
        int t;
        load_program(2);
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        rst = 1'b1; run = 1'b0; scan_period = 16'd20;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic scan, memory and executor always ready.
        run = 1'b1;
        wait_clears(3, 200, "basic_latches");
        check_eq("basic_count", scan_count, 16'd2);

        // Random programs, ack delays, back-pressure and ignored strobes.
        noise = 1'b1; ack_max = 3; ready_pct = 60;
        for (int s = 0; s < 25; s++) begin
            wait_clears(1, 400, "rand_latch");
            load_program($urandom_range(0, 10));
            scan_period = 16'($urandom_range(0, 40));
        end

        // Fixed back-pressure: 3-cycle fetch latency, 5 cycles of ex_ready low.
        wait_clears(1, 400, "bp_latch");
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = END_OP;
        noise = 1'b0; ack_fix = 3; hold_len = 5; ready_pct = 100; scan_period = '0;
        wait_clears(2, 200, "bp_scans");

        // run dropped during FETCH: the scan still commits, then IDLE.
        t = 0;
        while (!fetch_req && t < 100) begin tick(); t++; end
        check_eq("rundrop_fetch_seen", fetch_req, 1'b1);
        saved = m_scans;
        run = 1'b0;
        wait_idle(200, "rundrop_idle");
        check_eq("rundrop_count", scan_count, 16'(saved + 16'd1));
        repeat (5) tick();
        check_eq("rundrop_stays_idle", busy, 1'b0);

        // Reset while an instruction is being offered.
        run = 1'b1;
        t = 0;
        while (!ex_valid && t < 100) begin tick(); t++; end
        check_eq("rstissue_valid_seen", ex_valid, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("rstissue_valid_low", ex_valid, 1'b0);
        rst = 1'b0;
        wait_clears(2, 300, "rstissue_restart");

        // Address wrap: 16 non-END bytes, END on the second visit to address 0.
        run = 1'b0;
        wait_idle(300, "wrap_pre_idle");
        load_program(DEPTH);
        hold_len = 0; ack_fix = 0; scan_period = 16'd5; wrap_mode = 1'b1;
        saved = m_scans;
        run = 1'b1;
        wait_clears(1, 20, "wrap_latch");
        run = 1'b0;
        wait_idle(200, "wrap_idle");
        check_eq("wrap_count", scan_count, 16'(saved + 16'd1));
        check_eq("wrap_no_fault", fault, 1'b0);

        // Watchdog: no END in the program.
        wrap_mode = 1'b0;
        load_program(DEPTH);
        run = 1'b1;
        t = 0;
        while (!fault && t < 300) begin tick(); t++; end
        check_eq("wd_fault_seen", fault, 1'b1);
        repeat (10) tick();
        check_eq("wd_no_restart", busy, 1'b0);
        check_eq("wd_sticky", fault, 1'b1);
        run = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("wd_rst_clears", fault, 1'b0);
        rst = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog_timer
        #900000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/vslc_scan_sequencer.md
Name: vslc_scan_sequencer

Overview:
- Scan-cycle controller for the VSLC bit-stack executor.
- Each scan runs a fixed sequence: latch inputs, clear the stack, fetch program bytes and issue them to the executor until END, commit the executor's output image, then wait out the scan period.
- Sits between the program-memory fetch port, the executor and the top-level I/O pins.
- Adds a per-scan instruction watchdog.

Parameters:
- ADDR_W, 8, program address width.
- IO_W, 8, input and output image width.
- PERIOD_W, 16, scan-period counter width.
- MAX_INSTR, 255, watchdog limit on instructions issued per scan.
- END_OP, 8'hFF, opcode that terminates a scan.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  enable; scans start only while high.
- scan_period  in  PERIOD_W  minimum clk cycles from one LATCH to the next.
- in_pins  in  IO_W  raw input pins.
- in_image  out  IO_W  inputs latched for the current scan.
- fetch_req  out  1  program-byte request.
- fetch_addr  out  ADDR_W  program address.
- fetch_ack  in  1  fetch_data valid.
- fetch_data  in  8  program byte.
- ex_valid  out  1  instruction valid to the executor.
- ex_instr  out  8  instruction byte.
- ex_ready  in  1  executor accepts ex_instr.
- ex_clear  out  1  one-cycle pulse that clears the executor stack.
- ex_out_image  in  IO_W  executor's pending output image.
- out_pins  out  IO_W  committed outputs.
- busy  out  1  high in any state other than IDLE.
- fault  out  1  sticky watchdog fault.
- scan_count  out  16  completed scans, wraps modulo 2^16.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0, including fetch_addr, in_image, out_pins, fault and scan_count.
- Period counter: reset to 0 on entry to LATCH; increments every cycle in all other non-IDLE states, saturating at all-ones.
- States and transitions:
  - IDLE: if run && !fault, go to LATCH.
  - LATCH: in_image <= in_pins; ex_clear = 1 for exactly this cycle; fetch_addr <= 0; instruction counter <= 0; go to FETCH.
  - FETCH: hold fetch_req = 1 with a stable fetch_addr until fetch_ack.
    - On fetch_ack with fetch_data == END_OP: go to COMMIT.
    - On fetch_ack otherwise: register the byte into ex_instr and go to ISSUE.
    - fetch_ack may arrive in the same cycle fetch_req rises. There is no wait-cycle limit.
  - ISSUE: ex_valid = 1, with ex_instr held stable until ex_ready. On the ex_valid && ex_ready cycle:
    - fetch_addr += 1, wrapping modulo 2^ADDR_W;
    - instruction counter += 1;
    - if the counter has reached MAX_INSTR, set fault and go to IDLE; out_pins is left unchanged;
    - otherwise go to FETCH.
  - COMMIT: out_pins <= ex_out_image; scan_count += 1; go to WAIT.
  - WAIT: when period counter + 1 >= scan_period, go to LATCH if run && !fault, else IDLE.
    - If scan_period is 0 or 1, the LATCH follows COMMIT after one WAIT cycle.
- Control-signal latency: fetch_req and ex_valid are registered and never asserted together. A fetch_ack received outside FETCH is ignored.
- run falling mid-scan: the current scan completes through COMMIT, then the block enters IDLE at the end of WAIT.
- fault: sticky, cleared only by rst.
  - While fault is set, the block stays in IDLE and out_pins holds its last committed value.
  - fault is set on the same edge that IDLE is entered.
- Simultaneous events: rst has priority over everything; a fault has priority over run.
- busy = (state != IDLE), registered.

Decomposition:
- Package vslc_pkg holds:
  - the state enum: IDLE, LATCH, FETCH, ISSUE, COMMIT, WAIT;
  - the END_OP default;
  - the opcode width constant shared with the executor.
- One sub-module, vslc_scan_timer, holds the saturating period counter and the compare against scan_period. The FSM drives its restart on LATCH and reads back its done output.

Test Plan:
- Basic scan: program {0x12, 0x34, 0xFF}, run = 1, fetch_ack and ex_ready tied high, scan_period = 20 → ex_clear pulses once; ex_instr sequence is 0x12 then 0x34; out_pins = ex_out_image after COMMIT; scan_count = 1; the next LATCH occurs exactly 20 cycles after the previous LATCH.
- Back-pressure: ex_ready low for 5 cycles, fetch_ack delayed 3 cycles → ex_instr and fetch_addr stay stable throughout; no byte is lost or duplicated.
- Watchdog: program with no END_OP, MAX_INSTR = 4 → fault = 1 after the 4th accepted instruction; state is IDLE; out_pins is unchanged; asserting run does not restart; rst clears fault.
- Run drop mid-scan: deassert run during FETCH → the scan completes, scan_count increments by 1, then IDLE with busy = 0.
- Reset mid-ISSUE: assert rst for 1 cycle while ex_valid = 1 → the next cycle shows ex_valid = 0 and all outputs 0; the next scan starts from fetch_addr 0.
- Address wrap: ADDR_W = 4, program of 16 non-END bytes with END_OP at address 0 → fetch_addr wraps from 15 to 0 and the scan ends normally (MAX_INSTR = 255).
